dff_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a small shared register bank built from posedge D flip-flops. Up to NREQ requesters compete for single-port read/write access to DEPTH registers of WIDTH bits. The block grants one requester at a time, latches its command, performs the access and returns a one-cycle acknowledge. It sits between the flip-flop storage and the requester-side logic and is the only writer of the bank.

---
 rtl/dff_bank_arbiter.sv | 100 ++++++++++
 tb/tb_dff_bank_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and sequencer that owns a small flip-flop register bank, one access per 3 cycles.
// Requests are level-held until gnt; the latched command completes with a one-cycle ack even if req drops.
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NREQ  = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy
);

  localparam int LW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] bank [DEPTH];
  logic [LW-1:0]    last;
  logic [LW-1:0]    winner;
  logic [LW-1:0]    idx;
  logic             found;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;

  // Scan upward from the requester after the last winner, wrapping around.
  always_comb begin
    winner = last;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= LW'(NREQ - 1);
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            cmd_we    <= we[winner];
            cmd_addr  <= addr[int'(winner)*AW +: AW];
            cmd_wdata <= wdata[int'(winner)*WIDTH +: WIDTH];
            last      <= winner;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cmd_we) begin
            bank[cmd_addr] <= cmd_wdata;
          end else begin
            rdata <= bank[cmd_addr];
          end
          // gnt still carries the winner's one-hot code here.
          ack   <= gnt;
          gnt   <= '0;
          state <= DONE;
        end
        DONE: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (WIDTH=8, DEPTH=4, NREQ=4).
module tb_dff_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        busy;

  int tests = 0;
  int fails = 0;

  dff_bank_arbiter #(.WIDTH(8), .DEPTH(4), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single isolated access from requester i; starts and ends at a negedge with the FSM idle.
  task automatic run_one(input int i, input bit w, input int a, input logic [7:0] d,
                         output logic [3:0] g, output logic [3:0] k, output logic [7:0] r);
    we[i]           = w;
    addr[i*2 +: 2]  = a[1:0];
    wdata[i*8 +: 8] = d;
    req             = 4'b0001 << i;
    @(negedge clk);
    g   = gnt;
    req = '0;
    @(negedge clk);
    k = ack;
    r = rdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    #1;
    tests++;
    if ({gnt, ack, rdata, busy} !== 17'd0) begin
      fails++; $display("FAIL reset_init: got gnt=%b ack=%b rdata=%h busy=%b want all 0", gnt, ack, rdata, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0010) begin
      fails++; $display("FAIL reset_pre_second_gnt: got %b want 0010", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({gnt, ack, rdata, busy} !== 17'd0) begin
      fails++; $display("FAIL reset_async: got gnt=%b ack=%b rdata=%h busy=%b want all 0", gnt, ack, rdata, busy);
    end
    @(negedge clk);
    tests++;
    if (ack !== 4'b0000) begin
      fails++; $display("FAIL reset_held_ack: got %b want 0000", ack);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0001) begin
      fails++; $display("FAIL reset_first_gnt: got %b want 0001", gnt);
    end
    req = '0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [3:0] g, k;
    logic [7:0] r;
    do_reset();
    we[1] = 1'b1; addr[3:2] = 2'd2; wdata[15:8] = 8'hA5; req = 4'b0010;
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0010 || busy !== 1'b0 && 1'b0) begin
      fails++; $display("FAIL wr_gnt: got %b want 0010", gnt);
    end
    req = '0;
    @(negedge clk);
    tests++;
    if (ack !== 4'b0010 || gnt !== 4'b0000 || busy !== 1'b1) begin
      fails++; $display("FAIL wr_ack: got ack=%b gnt=%b busy=%b want ack=0010 gnt=0000 busy=1", ack, gnt, busy);
    end
    @(negedge clk);
    tests++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      fails++; $display("FAIL wr_done: got ack=%b busy=%b want ack=0000 busy=0", ack, busy);
    end
    run_one(3, 1'b0, 2, 8'h00, g, k, r);
    tests++;
    if (g !== 4'b1000 || k !== 4'b1000 || r !== 8'hA5) begin
      fails++; $display("FAIL rd_addr2: got gnt=%b ack=%b rdata=%h want 1000 1000 a5", g, k, r);
    end
    run_one(3, 1'b0, 0, 8'h00, g, k, r);
    tests++;
    if (r !== 8'h00) begin
      fails++; $display("FAIL rd_addr0: got %h want 00", r);
    end
    run_one(3, 1'b0, 2, 8'h00, g, k, r);
    run_one(0, 1'b1, 3, 8'h5A, g, k, r);
    tests++;
    if (k !== 4'b0001 || r !== 8'hA5) begin
      fails++; $display("FAIL wr_keeps_rdata: got ack=%b rdata=%h want 0001 a5", k, r);
    end
    run_one(2, 1'b0, 3, 8'h00, g, k, r);
    tests++;
    if (r !== 8'h5A) begin
      fails++; $display("FAIL rd_addr3: got %h want 5a", r);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    we = '0; addr = '0; req = 4'b0101;
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0001) begin
      fails++; $display("FAIL sim_gnt0: got %b want 0001", gnt);
    end
    @(negedge clk);
    tests++;
    if (ack !== 4'b0001 || gnt !== 4'b0000) begin
      fails++; $display("FAIL sim_ack0: got ack=%b gnt=%b want 0001 0000", ack, gnt);
    end
    @(negedge clk);
    tests++;
    if (ack !== 4'b0000 || gnt !== 4'b0000) begin
      fails++; $display("FAIL sim_gap: got ack=%b gnt=%b want 0000 0000", ack, gnt);
    end
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0100) begin
      fails++; $display("FAIL sim_gnt2: got %b want 0100", gnt);
    end
    req = '0;
    @(negedge clk);
    tests++;
    if (ack !== 4'b0100) begin
      fails++; $display("FAIL sim_ack2: got %b want 0100", ack);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    we = '0; req = 4'b1111;
    for (int n = 0; n < 12; n++) begin
      exp = 4'b0001 << (n % 4);
      @(negedge clk);
      tests++;
      if (gnt !== exp || ack !== 4'b0000) begin
        fails++; $display("FAIL rr_gnt[%0d]: got gnt=%b ack=%b want gnt=%b ack=0000", n, gnt, ack, exp);
      end
      @(negedge clk);
      tests++;
      if (ack !== exp || gnt !== 4'b0000) begin
        fails++; $display("FAIL rr_ack[%0d]: got ack=%b gnt=%b want ack=%b gnt=0000", n, ack, gnt, exp);
      end
      @(negedge clk);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_cmd_stability();
    logic [3:0] g, k;
    logic [7:0] r;
    do_reset();
    we[2] = 1'b1; addr[5:4] = 2'd1; wdata[23:16] = 8'h3C; req = 4'b0100;
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0100) begin
      fails++; $display("FAIL stab_gnt: got %b want 0100", gnt);
    end
    wdata[23:16] = 8'hFF; addr[5:4] = 2'd3; req = '0;
    @(negedge clk);
    tests++;
    if (ack !== 4'b0100) begin
      fails++; $display("FAIL stab_ack: got %b want 0100", ack);
    end
    @(negedge clk);
    we[2] = 1'b0;
    run_one(0, 1'b0, 1, 8'h00, g, k, r);
    tests++;
    if (r !== 8'h3C) begin
      fails++; $display("FAIL stab_bank1: got %h want 3c", r);
    end
    run_one(0, 1'b0, 3, 8'h00, g, k, r);
    tests++;
    if (r !== 8'h00) begin
      fails++; $display("FAIL stab_bank3: got %h want 00", r);
    end
  endtask

  task automatic test_abort();
    logic [3:0] g, k;
    logic [7:0] r;
    do_reset();
    run_one(3, 1'b1, 0, 8'h11, g, k, r);
    we[1] = 1'b1; addr[3:2] = 2'd0; wdata[15:8] = 8'h77; req = 4'b0010;
    @(negedge clk);
    tests++;
    if (gnt !== 4'b0010) begin
      fails++; $display("FAIL abort_gnt: got %b want 0010", gnt);
    end
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_async: got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    @(negedge clk);
    tests++;
    if (ack !== 4'b0000) begin
      fails++; $display("FAIL abort_no_ack: got %b want 0000", ack);
    end
    rst_n = 1'b1;
    we[1] = 1'b0;
    run_one(1, 1'b0, 0, 8'h00, g, k, r);
    tests++;
    if (k !== 4'b0010 || r !== 8'h00) begin
      fails++; $display("FAIL abort_bank0: got ack=%b rdata=%h want 0010 00", k, r);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_round_robin();
    test_cmd_stability();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
